noc_pipe_rx_buffer: RTL and testbench
=====================================

# noc_pipe_rx_buffer

Receive-side elastic buffer at the far end of a multi-cycle pipelined NoC link. It terminates the link that the `noc_pipe` latency stages feed. It absorbs every flit that is still in flight after it deasserts ready, so backpressure can travel through `LATENCY` register stages without losing data. The local router or client port then sees a normal first-word-fall-through valid/ready stream.

## Interface
Parameters:
- `VC_W`, default `DEFAULT_VC_W`: VC field width (one bit per VC).
- `A_W`, default 2: address field width.
- `D_W`, default `DEFAULT_D_W`: data field width.
- `LATENCY`, default 10: one-way pipeline stages of the link, in each direction. 0 is legal.
- `DEPTH`, default 32: buffer entries. Need not be a power of 2.
- `SKID`, derived as 2*`LATENCY`+1: slots reserved for in-flight flits. Elaboration error if `DEPTH` < `SKID`+1.

Ports:
- `clk`, input, 1: the block's single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_vld`, input, 1: flit arriving from the link.
- `in_addr`, input, `A_W`: arriving flit address.
- `in_data`, input, `D_W`: arriving flit payload.
- `in_vc`, input, `VC_W`: arriving flit VC.
- `in_rdy`, output, 1: registered ready, sent back upstream through the link.
- `out_vld`, output, 1: head flit is valid.
- `out_addr`, output, `A_W`: head flit address.
- `out_data`, output, `D_W`: head flit payload.
- `out_vc`, output, `VC_W`: head flit VC.
- `out_rdy`, input, 1: downstream accepts the head flit.
- `occupancy`, output, $clog2(`DEPTH`+1): current entry count.
- `max_occ`, output, $clog2(`DEPTH`+1): high-water mark of `occupancy` since reset.
- `overflow`, output, 1: sticky flag, set when a flit is dropped.

## Operation
- **Storage:** circular array with write pointer `wp`, read pointer `rp` and counter `cnt`. Both pointers wrap from `DEPTH`-1 to 0.
- **Push:** `in_vld`=1 and `cnt`<`DEPTH`. The flit is written at `wp`. `in_vld` is honoured regardless of `in_rdy`, because those flits are already in flight.
- **Pop:** `out_vld`=1 and `out_rdy`=1. `rp` advances.
- **Counter update:** `cnt_next` = `cnt` + push − pop.
  - Simultaneous push and pop leaves `cnt` unchanged.
  - When full, a push together with a pop is allowed: the pop frees the slot in the same cycle.
- **Overflow:** `in_vld`=1 while `cnt`=`DEPTH` and no pop.
  - The flit is dropped.
  - `overflow` is set and stays set until `rst`.
  - `cnt`, `wp` and stored data are unaffected.
- **Ready generation:** `in_rdy` is registered: `in_rdy` <= (`cnt_next` + `SKID` < `DEPTH`).
- **Output:** first-word-fall-through. `out_vld` = (`cnt` != 0). `out_*` fields are the entry at `rp`.
- **High-water mark:** `max_occ` <= max(`max_occ`, `cnt_next`).
- **Reset, including mid-operation:** asynchronously clears the following. Buffered flits are discarded.
  - `wp`, `rp`, `cnt` = 0.
  - `in_rdy` = 0, `out_vld` = 0.
  - `occupancy`, `max_occ`, `overflow` = 0.
  - `out_*` fields read from an unreset array and are don't-care while `out_vld`=0.

## Timing
- **Input to output latency:** 1 cycle. A flit pushed at edge k gives `out_vld`=1 after edge k when the buffer was previously empty.
- **Output path:** `out_vld` depends only on registered `cnt`. There is no combinational path from `in_*` to `out_*`.
- **Ready path:** there is no combinational path from `out_rdy` to `in_rdy`.
- **`in_rdy` after reset:** rises at the first `clk` edge after `rst` deasserts.
- **`in_rdy` falling:** falls at the edge where `cnt_next` reaches `DEPTH`−`SKID`. With the defaults this is `cnt_next`=11.
- **Loss-free guarantee:** a compliant upstream sends at most `SKID` further flits after that edge, so no flit is lost.
- **`in_rdy` rising:** rises at the edge where `cnt_next` drops below `DEPTH`−`SKID`.

## Test plan
- **Reset release:** hold `rst` 2 cycles, then release. `in_rdy`=0 and `out_vld`=0 during reset; `in_rdy`=1 one edge after release; `occupancy`=0.
- **Streaming:** `out_rdy`=1, 100 back-to-back flits with data 0..99. Each output appears 1 cycle after its input, in order; `max_occ`=1; `overflow`=0.
- **Skid fill (`LATENCY`=10, `DEPTH`=32):** `out_rdy`=0, upstream is a 10-stage model that honours `in_rdy`. `in_rdy` falls at the edge accepting flit 11; exactly 32 flits are stored in total; `overflow`=0; `max_occ`=32. Then set `out_rdy`=1: all 32 drain in order.
- **Overflow:** buffer full, `out_rdy`=0, force `in_vld` with data 0xDEAD. `overflow`=1 and `occupancy` stays 32. Drain: 0xDEAD never appears. Same cycle with `out_rdy`=1 instead: the flit is accepted and `overflow` stays 0.
- **Wrap, non-power-of-2 (`DEPTH`=30, `LATENCY`=2):** random push/pop at 50% until 200 flits have passed. Both pointers wrap at least 6 times; scoreboard order matches; `occupancy` never exceeds 30.
- **Reset mid-operation:** assert `rst` asynchronously, mid-cycle, with 15 entries held. `out_vld`, `in_rdy`, `occupancy`, `max_occ` and `overflow` go to 0 before the next edge; after release the first output is the first new flit.

Source files
------------

// File: rtl/noc_pipe_rx_buffer_if.sv
// Flit stream interface for the NoC pipe receive buffer: valid/ready handshake
// carrying address, payload and VC fields. The master drives the flit, the
// slave returns ready.

package noc_pipe_rx_buffer_pkg;
  localparam int DEFAULT_VC_W = 4;
  localparam int DEFAULT_D_W  = 16;
endpackage : noc_pipe_rx_buffer_pkg

interface noc_pipe_rx_buffer_if
  import noc_pipe_rx_buffer_pkg::*;
#(
  parameter int VC_W = DEFAULT_VC_W,
  parameter int A_W  = 2,
  parameter int D_W  = DEFAULT_D_W
);
  logic            vld;
  logic [A_W-1:0]  addr;
  logic [D_W-1:0]  data;
  logic [VC_W-1:0] vc;
  logic            rdy;

  modport master (
    output vld,
    output addr,
    output data,
    output vc,
    input  rdy
  );

  modport slave (
    input  vld,
    input  addr,
    input  data,
    input  vc,
    output rdy
  );
endinterface : noc_pipe_rx_buffer_if

// File: rtl/noc_pipe_rx_buffer.sv
// Receive-side elastic buffer terminating a multi-cycle pipelined NoC link.
// Incoming flits are accepted whenever space exists, even with ready low,
// because they were launched before the registered ready could travel back
// through the link. Ready is withheld early enough to keep 2*LATENCY+1 slots
// free for those in-flight flits. The local side sees a first-word-fall-through
// valid/ready stream.

module noc_pipe_rx_buffer
  import noc_pipe_rx_buffer_pkg::*;
#(
  parameter int VC_W    = DEFAULT_VC_W,
  parameter int A_W     = 2,
  parameter int D_W     = DEFAULT_D_W,
  parameter int LATENCY = 10,
  parameter int DEPTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  noc_pipe_rx_buffer_if.slave        in_if,
  noc_pipe_rx_buffer_if.master       out_if,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] max_occ,
  output logic                       overflow
);

  // Round trip of the link: LATENCY stages back for ready, LATENCY stages
  // forward for data, plus the ready register itself.
  localparam int SKID  = 2 * LATENCY + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (LATENCY < 0) begin : g_latency_check
    $error("noc_pipe_rx_buffer: LATENCY must be non-negative");
  end
  if (DEPTH < SKID + 1) begin : g_depth_check
    $error("noc_pipe_rx_buffer: DEPTH must be at least 2*LATENCY+2");
  end

  typedef struct packed {
    logic [VC_W-1:0] vc;
    logic [A_W-1:0]  addr;
    logic [D_W-1:0]  data;
  } flit_t;

  flit_t            mem_q [DEPTH];
  flit_t            wr_flit;

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] max_occ_q, max_occ_d;
  logic             in_rdy_q, in_rdy_d;
  logic             overflow_q, overflow_d;

  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  // Advance a pointer with wrap at DEPTH-1, so DEPTH need not be a power of 2.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: a pop in the same cycle frees a slot for a push when full.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    full = 1'b0;
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    full = (cnt_q == CNT_W'(DEPTH));
    pop  = (cnt_q != '0) && out_if.rdy;
    push = in_if.vld && (!full || pop);
    drop = in_if.vld && full && !pop;
  end

  // Next-state for pointers, count, ready, high-water mark and sticky overflow.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    max_occ_d  = max_occ_q;
    overflow_d = overflow_q;
    in_rdy_d   = 1'b0;

    if (push) begin
      wp_d = ptr_inc(wp_q);
    end
    if (pop) begin
      rp_d = ptr_inc(rp_q);
    end

    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    // Ready drops once fewer than SKID+1 slots would remain free.
    in_rdy_d   = (int'(cnt_d) + SKID) < DEPTH;
    max_occ_d  = (cnt_d > max_occ_q) ? cnt_d : max_occ_q;
    overflow_d = overflow_q | drop;
  end

  // Control state registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      max_occ_q  <= '0;
      in_rdy_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge inputs regardless of statement order.
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      max_occ_q  <= max_occ_d;
      in_rdy_q   <= in_rdy_d;
      overflow_q <= overflow_d;
    end
  end

  // Pack the arriving flit into one storage word.
  always_comb begin
    wr_flit      = '0;
    wr_flit.vc   = in_if.vc;
    wr_flit.addr = in_if.addr;
    wr_flit.data = in_if.data;
  end

  // Flit storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale words are never visible
    // because out_vld is qualified by the reset count.
    if (push) begin
      mem_q[wp_q] <= wr_flit;
    end
  end

  // First-word-fall-through head and status outputs, all from registered state.
  assign out_if.vld  = (cnt_q != '0);
  assign out_if.vc   = mem_q[rp_q].vc;
  assign out_if.addr = mem_q[rp_q].addr;
  assign out_if.data = mem_q[rp_q].data;
  assign in_if.rdy   = in_rdy_q;
  assign occupancy   = cnt_q;
  assign max_occ     = max_occ_q;
  assign overflow    = overflow_q;

endmodule : noc_pipe_rx_buffer

// File: tb/tb_noc_pipe_rx_buffer.sv
// Directed bench for noc_pipe_rx_buffer. Instance A uses the defaults
// (LATENCY=10, DEPTH=32); instance B uses DEPTH=30, LATENCY=2 for wrap checks.
// Inputs are driven and outputs sampled at the falling clock edge.

module tb_noc_pipe_rx_buffer;

  localparam int A_LAT = 10;
  localparam int A_DEP = 32;
  localparam int B_LAT = 2;
  localparam int B_DEP = 30;

  logic clk;
  logic rst_a;
  logic rst_b;

  noc_pipe_rx_buffer_if #(.VC_W(4), .A_W(2), .D_W(16)) a_in ();
  noc_pipe_rx_buffer_if #(.VC_W(4), .A_W(2), .D_W(16)) a_out ();
  noc_pipe_rx_buffer_if #(.VC_W(4), .A_W(2), .D_W(16)) b_in ();
  noc_pipe_rx_buffer_if #(.VC_W(4), .A_W(2), .D_W(16)) b_out ();

  logic [5:0] a_occ, a_max;
  logic       a_ovf;
  logic [4:0] b_occ, b_max;
  logic       b_ovf;

  int n_checks = 0;
  int n_errors = 0;

  noc_pipe_rx_buffer #(
    .VC_W(4), .A_W(2), .D_W(16), .LATENCY(A_LAT), .DEPTH(A_DEP)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst_a),
    .in_if    (a_in),
    .out_if   (a_out),
    .occupancy(a_occ),
    .max_occ  (a_max),
    .overflow (a_ovf)
  );

  noc_pipe_rx_buffer #(
    .VC_W(4), .A_W(2), .D_W(16), .LATENCY(B_LAT), .DEPTH(B_DEP)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .in_if    (b_in),
    .out_if   (b_out),
    .occupancy(b_occ),
    .max_occ  (b_max),
    .overflow (b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus to A, return at the following falling edge.
  task automatic a_drive(input logic vld, input logic [15:0] d, input logic rdy);
    a_in.vld   = vld;
    a_in.data  = d;
    a_in.addr  = d[1:0];
    a_in.vc    = d[5:2];
    a_out.rdy  = rdy;
    @(negedge clk);
  endtask

  task automatic b_drive(input logic vld, input logic [15:0] d, input logic rdy);
    b_in.vld   = vld;
    b_in.data  = d;
    b_in.addr  = d[1:0];
    b_in.vc    = d[5:2];
    b_out.rdy  = rdy;
    @(negedge clk);
  endtask

  // Check the head of A against an expected flit, then pop it.
  task automatic a_pop_expect(input string tag, input logic [15:0] d);
    check({tag, "_vld"}, a_out.vld, 1);
    check({tag, "_data"}, a_out.data, d);
    check({tag, "_addr"}, a_out.addr, d[1:0]);
    check({tag, "_vc"}, a_out.vc, d[5:2]);
    a_drive(1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    bit          rdy_pipe [A_LAT+1];
    bit          fwd_v    [A_LAT+1];
    logic [15:0] fwd_d    [A_LAT+1];
    logic [15:0] sb [$];
    logic        cur_v;
    logic [15:0] cur_d;
    int          sent;
    int          arr;
    int          passed;
    int          cyc;
    logic        v;
    logic        r;
    logic [15:0] d;

    rst_a = 1'b1;
    rst_b = 1'b1;
    a_in.vld = 1'b0; a_in.data = '0; a_in.addr = '0; a_in.vc = '0; a_out.rdy = 1'b0;
    b_in.vld = 1'b0; b_in.data = '0; b_in.addr = '0; b_in.vc = '0; b_out.rdy = 1'b0;

    // Reset release
    repeat (2) begin
      @(negedge clk);
      check("rst_in_rdy", a_in.rdy, 0);
      check("rst_out_vld", a_out.vld, 0);
      check("rst_occ", a_occ, 0);
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check("rel_in_rdy_before_edge", a_in.rdy, 0);
    @(negedge clk);
    check("rel_in_rdy", a_in.rdy, 1);
    check("rel_occ", a_occ, 0);
    check("rel_max", a_max, 0);
    check("rel_ovf", a_ovf, 0);
    check("rel_b_in_rdy", b_in.rdy, 1);

    // Streaming: each flit is the head one cycle after it is pushed
    for (int i = 0; i < 100; i++) begin
      a_drive(1'b1, 16'(i), 1'b1);
      check("stream_vld", a_out.vld, 1);
      check("stream_data", a_out.data, 32'(i));
      check("stream_occ", a_occ, 1);
    end
    a_drive(1'b0, 16'h0, 1'b1);
    check("stream_empty", a_out.vld, 0);
    check("stream_max", a_max, 1);
    check("stream_ovf", a_ovf, 0);
    check("stream_in_rdy", a_in.rdy, 1);

    // Skid fill: upstream source with a registered output feeding LATENCY
    // forward stages, seeing in_rdy through LATENCY backward stages.
    foreach (rdy_pipe[k]) rdy_pipe[k] = 1'b1;
    foreach (fwd_v[k]) begin
      fwd_v[k] = 1'b0;
      fwd_d[k] = '0;
    end
    sent = 0;
    arr  = 0;
    for (int c = 0; c < 80; c++) begin
      cur_v = fwd_v[A_LAT];
      cur_d = fwd_d[A_LAT];
      for (int k = A_LAT; k > 0; k--) begin
        fwd_v[k]    = fwd_v[k-1];
        fwd_d[k]    = fwd_d[k-1];
        rdy_pipe[k] = rdy_pipe[k-1];
      end
      rdy_pipe[0] = a_in.rdy;
      fwd_v[0]    = rdy_pipe[A_LAT];
      fwd_d[0]    = 16'h100 + 16'(sent);
      if (fwd_v[0]) sent++;
      if (cur_v) arr++;
      a_drive(cur_v, cur_d, 1'b0);
      check("skid_in_rdy", a_in.rdy, (arr < 11) ? 1 : 0);
      check("skid_occ", a_occ, 32'(arr));
    end
    check("skid_total", 32'(arr), 32);
    check("skid_ovf", a_ovf, 0);
    check("skid_max", a_max, 32);
    for (int i = 0; i < 32; i++) a_pop_expect("skid_drain", 16'h100 + 16'(i));
    check("skid_drain_empty", a_out.vld, 0);
    check("skid_drain_occ", a_occ, 0);

    // Overflow: full, no pop, extra flit dropped
    for (int i = 0; i < 32; i++) a_drive(1'b1, 16'h200 + 16'(i), 1'b0);
    check("ovf_full_occ", a_occ, 32);
    check("ovf_full_in_rdy", a_in.rdy, 0);
    check("ovf_pre", a_ovf, 0);
    a_drive(1'b1, 16'hDEAD, 1'b0);
    check("ovf_set", a_ovf, 1);
    check("ovf_occ", a_occ, 32);
    a_drive(1'b0, 16'h0, 1'b0);
    check("ovf_sticky", a_ovf, 1);
    for (int i = 0; i < 32; i++) a_pop_expect("ovf_drain", 16'h200 + 16'(i));
    check("ovf_drain_empty", a_out.vld, 0);
    check("ovf_sticky_after_drain", a_ovf, 1);

    // Full with a simultaneous pop: the push is accepted
    rst_a = 1'b1;
    @(negedge clk);
    check("ovf_cleared_by_rst", a_ovf, 0);
    rst_a = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 32; i++) a_drive(1'b1, 16'h300 + 16'(i), 1'b0);
    check("fullpop_occ_pre", a_occ, 32);
    check("fullpop_max", a_max, 32);
    a_drive(1'b1, 16'hDEAD, 1'b1);
    check("fullpop_ovf", a_ovf, 0);
    check("fullpop_occ", a_occ, 32);
    for (int i = 1; i < 32; i++) a_pop_expect("fullpop_drain", 16'h300 + 16'(i));
    a_pop_expect("fullpop_last", 16'hDEAD);
    check("fullpop_empty", a_out.vld, 0);
    check("fullpop_ovf_end", a_ovf, 0);

    // Reset mid-operation with 15 entries held
    for (int i = 0; i < 15; i++) a_drive(1'b1, 16'h400 + 16'(i), 1'b0);
    check("midrst_occ_pre", a_occ, 15);
    a_in.vld = 1'b0;
    #2;
    rst_a = 1'b1;
    #1;
    check("midrst_out_vld", a_out.vld, 0);
    check("midrst_in_rdy", a_in.rdy, 0);
    check("midrst_occ", a_occ, 0);
    check("midrst_max", a_max, 0);
    check("midrst_ovf", a_ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    a_drive(1'b1, 16'h04A5, 1'b0);
    check("midrst_in_rdy_after", a_in.rdy, 1);
    check("midrst_occ_new", a_occ, 1);
    a_pop_expect("midrst_first", 16'h04A5);
    check("midrst_empty", a_out.vld, 0);

    // Wrap on DEPTH=30: random push/pop against a scoreboard
    passed = 0;
    cyc    = 0;
    while (passed < 200 && cyc < 5000) begin
      check("wrap_vld", b_out.vld, (sb.size() != 0) ? 1 : 0);
      if (sb.size() != 0) check("wrap_data", b_out.data, sb[0]);
      check("wrap_occ", b_occ, 32'(sb.size()));
      v = ($urandom_range(1, 0) == 1) && (sb.size() < B_DEP);
      r = ($urandom_range(1, 0) == 1);
      d = 16'($urandom);
      if (r && sb.size() != 0) begin
        void'(sb.pop_front());
        passed++;
      end
      if (v) sb.push_back(d);
      b_drive(v, d, r);
      cyc++;
    end
    check("wrap_count", 32'(passed), 200);
    check("wrap_ovf", b_ovf, 0);
    check("wrap_max_le_depth", (b_max <= 5'(B_DEP)) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_noc_pipe_rx_buffer
